// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - LSB-first serial-to-parallel receive stage
// Reassembles WIDTH-bit words into a single-entry valid/ready holding register.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             s_start,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-2:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             overrun_q, overrun_d;
  logic             pop, drop;

  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    overrun_d = overrun_q;
    pop       = p_valid_q && p_ready;
    drop      = 1'b0;

    if (pop) p_valid_d = 1'b0;

    if (s_valid) begin
      if (s_start) begin
        // A framing marker restarts assembly; any partial word is discarded.
        sh_d    = '0;
        sh_d[0] = s_in;
        cnt_d   = CW'(1);
      end else if (cnt_q == LAST) begin
        cnt_d = '0;
        if (!p_valid_q || pop) begin
          p_out_d   = {s_in, sh_q};
          p_valid_d = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else begin
        for (int i = 0; i < WIDTH - 1; i++) begin
          if (cnt_q == CW'(i)) sh_d[i] = s_in;
        end
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (drop) overrun_d = 1'b1;
    else if (clr_ovr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign overrun = overrun_q;
  assign busy    = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - scoreboard bench for sipo_deserializer
// Driver feeds a word-level model and queue; monitors compare DUT outputs.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_in = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_start = 1'b0;
  logic [W-1:0] p_out;
  logic         p_valid;
  logic         p_ready = 1'b0;
  logic         busy;
  logic         overrun;
  logic         clr_ovr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  m_word = 0;
  int           m_len  = 0;
  bit           m_full = 1'b0;
  bit           m_ovr  = 1'b0;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_start(s_start),
    .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready), .busy(busy),
    .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus and advances the word-level model for that edge.
  task automatic drive(input bit i_rst, input bit i_valid, input bit i_start,
                       input bit i_bit, input bit i_ready, input bit i_clr);
    bit pop, load, drop;
    rst = i_rst; s_valid = i_valid; s_start = i_start;
    s_in = i_bit; p_ready = i_ready; clr_ovr = i_clr;
    pop = 0; load = 0; drop = 0;
    if (!i_rst) begin
      exp_q.delete();
      m_word = 0; m_len = 0; m_full = 0; m_ovr = 0;
    end else begin
      pop = m_full && i_ready;
      if (i_valid) begin
        if (i_start) begin
          m_word = 32'(i_bit);
          m_len  = 1;
        end else begin
          m_word = m_word | (32'(i_bit) << m_len);
          m_len++;
        end
        if (m_len == W) begin
          if (!m_full || pop) begin
            exp_q.push_back(m_word[W-1:0]);
            load = 1;
          end else begin
            drop = 1;
          end
          m_len  = 0;
          m_word = 0;
        end
      end
      if (load) m_full = 1;
      else if (pop) m_full = 0;
      if (drop) m_ovr = 1;
      else if (i_clr) m_ovr = 0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic send_word(input logic [3:0] w, input bit start,
                           input logic [3:0] rdy, input bit clr);
    for (int i = 0; i < 4; i++) drive(1, 1, start && (i == 0), w[i], rdy[i], clr);
  endtask

  task automatic idle(input bit rdy, input bit clr);
    drive(1, 0, 0, 1'($urandom), rdy, clr);
  endtask

  // Flag monitor: state just after each edge must match the model.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check("p_valid", 32'(p_valid), 32'(m_full));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("busy", 32'(busy), 32'(m_len != 0));
    end
  end

  // Data monitor: held word must match queue head; pop on handshake.
  always @(negedge clk) begin
    if (mon_en && rst && p_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(p_out), 32'hFFFF_FFFF);
      end else begin
        check("p_out_sb", 32'(p_out), 32'(exp_q[0]));
        if (p_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst_p_out", 32'(p_out), 0);
    check("rst_p_valid", 32'(p_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    mon_en = 1;

    // Single word 4'hB
    drive(1, 1, 1, 1, 1, 0); check("busy_b1", 32'(busy), 1);
    drive(1, 1, 0, 1, 1, 0); check("busy_b2", 32'(busy), 1);
    drive(1, 1, 0, 0, 1, 0); check("busy_b3", 32'(busy), 1);
    drive(1, 1, 0, 1, 1, 0);
    check("single_p_out", 32'(p_out), 32'hB);
    check("single_p_valid", 32'(p_valid), 1);
    idle(1, 0);

    // Gaps and backpressure with 4'h5
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    idle(0, 0); idle(0, 0);
    check("gap_busy", 32'(busy), 1);
    drive(1, 1, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("hold_p_out", 32'(p_out), 32'h5);
      idle(0, 0);
    end
    check("hold_p_valid", 32'(p_valid), 1);
    idle(1, 0);
    check("pop_p_valid", 32'(p_valid), 0);

    // Overrun, clear, and set-wins-over-clear
    send_word(4'hA, 1, 4'h0, 0);
    send_word(4'h3, 1, 4'h0, 0);
    check("ovr_p_out", 32'(p_out), 32'hA);
    check("ovr_set", 32'(overrun), 1);
    idle(0, 1);
    check("ovr_clr", 32'(overrun), 0);
    send_word(4'h5, 1, 4'h0, 1);
    check("ovr_set_wins", 32'(overrun), 1);
    check("ovr_p_out2", 32'(p_out), 32'hA);
    idle(1, 1);

    // Completion coinciding with pop
    send_word(4'h6, 1, 4'h0, 0);
    send_word(4'h9, 1, 4'h8, 0);
    check("simul_p_out", 32'(p_out), 32'h9);
    check("simul_p_valid", 32'(p_valid), 1);
    check("simul_overrun", 32'(overrun), 0);
    idle(1, 0);

    // Realign after a partial word
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 0);
    send_word(4'hC, 1, 4'h0, 0);
    check("realign_p_out", 32'(p_out), 32'hC);
    check("realign_overrun", 32'(overrun), 0);
    idle(1, 0);

    // Reset mid-word, then a clean unframed word
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 0);
    drive(0, 1, 0, 1, 1, 0);
    check("midrst_busy", 32'(busy), 0);
    send_word(4'h7, 0, 4'h0, 0);
    check("midrst_p_out", 32'(p_out), 32'h7);
    idle(1, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) != 0, $urandom_range(9) < 7, $urandom_range(9) == 0,
            1'($urandom), $urandom_range(9) < 6, $urandom_range(19) == 0);
    end

    // Drain: every loaded word must have been delivered
    for (int i = 0; i < 3; i++) idle(1, 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receive stage that sits directly downstream of the 4-bit PISO transmitter. It reassembles LSB-first serial bits into WIDTH-bit words and presents each completed word on a single-entry valid/ready output register. It provides frame realignment, drop-on-full overrun detection and a busy indication. One bit is accepted per qualified clock.

## Interface
Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- s_in  in  1  serial data bit, LSB of word first.
- s_valid  in  1  s_in is valid this cycle; bits are captured only when high.
- s_start  in  1  framing marker; when high with s_valid, this bit is bit 0 of a new word.
- p_out  out  WIDTH  assembled word; stable while p_valid is high.
- p_valid  out  1  p_out holds an unconsumed word.
- p_ready  in  1  consumer accepts p_out when p_valid && p_ready.
- busy  out  1  a partial word is in progress (bit count != 0).
- overrun  out  1  sticky flag: a completed word was dropped.
- clr_ovr  in  1  single-cycle pulse that clears overrun.

## Operation
- Internal state:
  - shift register sh[WIDTH-2:0];
  - bit counter cnt, width $clog2(WIDTH), range 0..WIDTH-1;
  - holding register p_out/p_valid.
- Capture: on s_valid, s_in is written to bit position cnt of the word being assembled.
  - LSB-first: the first bit received lands in p_out[0].
  - cnt increments; no wrap beyond WIDTH-1.
- Framing: s_valid && s_start forces the current bit to position 0.
  - Any partial word is discarded silently; this is not an overrun.
  - cnt becomes 1, or completes immediately if WIDTH==1 (illegal, not supported).
- Gaps: s_valid low holds sh and cnt unchanged. No timeout.
- Completion: when s_valid is high and cnt==WIDTH-1:
  - the full word {s_in, sh} is formed and cnt returns to 0;
  - the word is loaded into the holding register if the register is empty or is being popped this cycle;
  - otherwise the word is dropped, overrun sets to 1, and the existing p_out is left untouched.
- Pop: p_valid && p_ready clears p_valid at the next edge, unless a completion reloads it in the same cycle.
- Overrun:
  - set by a drop;
  - cleared by clr_ovr;
  - if set and clear occur in the same cycle, set wins.
- busy = (cnt != 0), driven combinationally from the register.
- Reset (rst==0 at an edge), applies mid-word or mid-handshake:
  - cnt=0, sh=0;
  - p_out=0, p_valid=0;
  - overrun=0, busy=0.
  - Inputs are ignored during the reset cycle.

## Timing
- Latency: p_valid rises at the edge that captures the last bit. The word is visible the cycle after the last bit is presented.
- Back-to-back throughput: a word every WIDTH cycles with s_valid held high and p_ready high.
- p_out and p_valid are registered. No combinational path from p_ready to p_valid or p_out.
- A completion and a pop in the same cycle keep p_valid=1 and update p_out to the new word with no bubble.
- p_out is undefined-by-contract but actually holds its last value after a pop. The bench checks p_out only when p_valid=1.
- Priority at the completion edge: reset > framing (s_start) > completion > gap hold.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs, then check:
  - p_out=0, p_valid=0, busy=0, overrun=0.
- Single word, WIDTH=4: send bits 1,1,0,1 on consecutive cycles, s_start on the first, p_ready=1. Check:
  - p_out=4'hB and p_valid=1 in the cycle after bit 3;
  - busy=1 during bits 1-3.
- Gaps and backpressure: send 4'h5 with s_valid low for 2 cycles between bits 1 and 2, with p_ready=0. Check:
  - p_out=4'h5 is held until p_ready is raised;
  - p_valid drops the cycle after the pop.
- Overrun: with p_ready=0, send 4'hA then 4'h3. Check:
  - p_out stays 4'hA and overrun=1;
  - clr_ovr then clears overrun;
  - clr_ovr together with another drop leaves overrun=1.
- Simultaneous pop/complete: p_valid=1 with 4'h6, p_ready=1 on the cycle the last bit of 4'h9 arrives. Check:
  - next cycle p_out=4'h9, p_valid=1;
  - no overrun.
- Realign and reset mid-word:
  - send 2 bits, then assert s_start with bits 0,0,1,1: check p_out=4'hC with no overrun;
  - separately, assert rst after 3 bits: check busy=0, and the next 4 bits form a clean word.
